// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: multi-cycle RV32I data memory for the MEM stage.
//
// Accepts one load/store per valid/ready handshake, spends LATENCY cycles busy,
// then presents a one-cycle registered response. After reset the array is
// cleared by a hardware sweep (word 0 gets INIT_WORD0) before any request is
// accepted.
//
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   req_valid   request present
//   req_ready   controller can accept a request
//   req_we      1 = store, 0 = load
//   req_funct3  RV32I funct3 of the access
//   req_addr    byte address
//   req_wdata   store data, right-aligned
//   resp_valid  one-cycle response pulse
//   resp_rdata  extended load data; 0 for stores and errors
//   resp_err    access rejected (misaligned, out of range, illegal funct3)
//   init_done   init sweep complete, held until next reset
module data_mem_ctrl #(
  parameter int unsigned DEPTH      = 64,
  parameter int unsigned LATENCY    = 1,
  parameter logic [31:0] INIT_WORD0 = 32'h0A00_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        init_done
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam logic [IW-1:0] LastIdx = IW'(DEPTH - 1);

  typedef enum logic [1:0] {StInit, StIdle, StBusy, StResp} state_e;

  state_e        state_q;
  logic [IW-1:0] init_cnt_q;
  logic [3:0]    busy_cnt_q;
  logic          we_q;
  logic [2:0]    funct3_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;

  logic [31:0]   mem [DEPTH];

  // Decode of the latched request
  logic [IW-1:0] idx;
  logic [1:0]    lane;
  logic [31:0]   rd_word;
  logic          illegal;
  logic          misaligned;
  logic          out_of_range;
  logic          acc_err;
  logic [7:0]    lane_byte;
  logic [15:0]   lane_half;
  logic [31:0]   load_data;
  logic [31:0]   merged_word;
  logic          busy_last;

  // Array write port
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  assign idx          = addr_q[IW+1:2];
  assign lane         = addr_q[1:0];
  assign rd_word      = mem[idx];
  assign out_of_range = (addr_q >> (IW + 2)) != 32'd0;
  assign busy_last    = (state_q == StBusy) && (busy_cnt_q == 4'd0);

  always_comb begin
    if (we_q) begin
      illegal = funct3_q > 3'b010;
    end else begin
      illegal = (funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11);
    end
    // funct3[1:0] encodes size for every legal op: 00 byte, 01 half, 10 word
    misaligned = ((funct3_q[1:0] == 2'b01) && lane[0]) ||
                 ((funct3_q[1:0] == 2'b10) && (lane != 2'b00));
    acc_err    = illegal || misaligned || out_of_range;

    lane_byte = rd_word[{lane, 3'b000} +: 8];
    lane_half = lane[1] ? rd_word[31:16] : rd_word[15:0];

    load_data = '0;
    case (funct3_q)
      3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
      3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
      3'b010:  load_data = rd_word;
      3'b100:  load_data = {24'd0, lane_byte};
      3'b101:  load_data = {16'd0, lane_half};
      default: load_data = '0;
    endcase

    // Read-modify-write: untouched lanes keep their current contents
    merged_word = rd_word;
    case (funct3_q[1:0])
      2'b00: merged_word[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'b01: begin
        if (lane[1]) begin
          merged_word[31:16] = wdata_q[15:0];
        end else begin
          merged_word[15:0] = wdata_q[15:0];
        end
      end
      2'b10:   merged_word = wdata_q;
      default: merged_word = rd_word;
    endcase
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = idx;
    mem_wdata = merged_word;
    if (state_q == StInit) begin
      mem_we    = 1'b1;
      mem_waddr = init_cnt_q;
      mem_wdata = (init_cnt_q == '0) ? INIT_WORD0 : 32'd0;
    end else if (busy_last && we_q && !acc_err) begin
      mem_we = 1'b1;
    end
  end

  // Array has no reset; the sweep defines its contents. While reset is held
  // the FSM sits in StInit, so no pending store can reach the array.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StInit;
      init_cnt_q <= '0;
      busy_cnt_q <= '0;
      we_q       <= 1'b0;
      funct3_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      unique case (state_q)
        StInit: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LastIdx) begin
            state_q   <= StIdle;
            req_ready <= 1'b1;
            init_done <= 1'b1;
          end
        end
        StIdle: begin
          if (req_valid) begin
            we_q       <= req_we;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            busy_cnt_q <= 4'(LATENCY - 1);
            req_ready  <= 1'b0;
            state_q    <= StBusy;
          end
        end
        StBusy: begin
          if (busy_cnt_q == 4'd0) begin
            resp_rdata <= (we_q || acc_err) ? 32'd0 : load_data;
            resp_err   <= acc_err;
            resp_valid <= 1'b1;
            state_q    <= StResp;
          end else begin
            busy_cnt_q <= busy_cnt_q - 4'd1;
          end
        end
        StResp: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= StIdle;
        end
        default: state_q <= StInit;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: the driver pushes expected responses,
// a negedge monitor pops and compares whenever resp_valid is seen.
module tb_data_mem_ctrl;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 3;
  localparam logic [31:0] INIT0   = 32'h0A00_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        init_done;

  data_mem_ctrl #(
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .INIT_WORD0(INIT0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .resp_err  (resp_err),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int n_resp = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned due;
  } exp_t;
  exp_t sb[$];

  logic [31:0] model [DEPTH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) model[i] = 32'd0;
    model[0] = INIT0;
  endtask

  // Behavioural model: size/sign from the op, byte-wise access on the word.
  task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int unsigned size, off;
    bit legal, sgn;
    logic [31:0] word, v;
    legal = 1'b1;
    sgn   = 1'b0;
    size  = 4;
    case (f3)
      3'd0:    begin size = 1; sgn = !we; end
      3'd1:    begin size = 2; sgn = !we; end
      3'd2:    size = 4;
      3'd4:    begin size = 1; legal = !we; end
      3'd5:    begin size = 2; legal = !we; end
      default: legal = 1'b0;
    endcase
    err = !legal || (addr % size != 0) || (addr >= 32'(4 * DEPTH));
    rd  = 32'd0;
    if (err) return;
    word = model[addr / 4];
    off  = addr % 4;
    if (we) begin
      for (int i = 0; i < int'(size); i++) word[8 * (int'(off) + i) +: 8] = wd[8 * i +: 8];
      model[addr / 4] = word;
    end else begin
      v = word >> (8 * off);
      if (size == 1) begin
        v = v & 32'hFF;
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end else if (size == 2) begin
        v = v & 32'hFFFF;
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      rd = v;
    end
  endtask

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input bit hold, input bit use_exp,
                        input logic [31:0] erd, input logic eerr, output int unsigned acc);
    int n;
    exp_t e;
    logic [31:0] mrd;
    logic merr;
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 after %0d cycles", n);
      req_valid = 1'b0;
      acc = 0;
      return;
    end
    acc = cyc + 1;
    model_access(we, f3, addr, wd, mrd, merr);
    e.rdata = use_exp ? erd : mrd;
    e.err   = use_exp ? eerr : merr;
    e.due   = acc + LATENCY;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold) req_valid = 1'b0;
    // Latched values must be used; scramble the bus after acceptance
    req_addr   = $urandom();
    req_wdata  = $urandom();
    req_funct3 = 3'($urandom());
    req_we     = 1'($urandom());
    @(negedge clk);
  endtask

  task automatic wait_init(input string name);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({name, "_ready_cycles"}, 32'(n), 32'(DEPTH));
    check({name, "_init_done"}, {31'd0, init_done}, 32'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_req_ready"}, {31'd0, req_ready}, 32'd0);
    check({name, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({name, "_resp_rdata"}, resp_rdata, 32'd0);
    check({name, "_resp_err"}, {31'd0, resp_err}, 32'd0);
    check({name, "_init_done"}, {31'd0, init_done}, 32'd0);
  endtask

  // Monitor
  always @(negedge clk) begin
    if (resp_valid) begin
      n_resp++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        check("resp_cycle", cyc, e.due);
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } dir_t;
  dir_t dirs[$];

  task automatic add_dir(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [31:0] erd, input logic eerr);
    dir_t d;
    d.we = we; d.f3 = f3; d.addr = addr; d.wd = wd; d.erd = erd; d.eerr = eerr;
    dirs.push_back(d);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int unsigned acc, prev_acc, resp_before;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    model_reset();

    // Hold a LW 0 pending across the whole sweep
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0;
    reset      = 1'b1;
    wait_init("init");
    do_req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 1'b1, INIT0, 1'b0, acc);
    do_req(1'b0, 3'b010, 32'hFC, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, acc);

    add_dir(1'b1, 3'b000, 32'h11, 32'h0000_00F0, 32'h0, 1'b0);
    add_dir(1'b0, 3'b000, 32'h11, 32'h0, 32'hFFFF_FFF0, 1'b0);
    add_dir(1'b0, 3'b100, 32'h11, 32'h0, 32'h0000_00F0, 1'b0);
    add_dir(1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_F000, 1'b0);
    add_dir(1'b1, 3'b001, 32'h22, 32'h0000_8001, 32'h0, 1'b0);
    add_dir(1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8001, 1'b0);
    add_dir(1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_8001, 1'b0);
    add_dir(1'b1, 3'b010, 32'h24, 32'hDEAD_BEEF, 32'h0, 1'b0);
    add_dir(1'b0, 3'b010, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0);
    add_dir(1'b0, 3'b001, 32'h23, 32'h0, 32'h0, 1'b1);
    add_dir(1'b0, 3'b010, 32'h26, 32'h0, 32'h0, 1'b1);
    add_dir(1'b1, 3'b010, 32'h100, 32'h5555_5555, 32'h0, 1'b1);
    add_dir(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1);
    add_dir(1'b1, 3'b001, 32'h25, 32'h0000_1234, 32'h0, 1'b1);
    add_dir(1'b1, 3'b011, 32'h10, 32'hFFFF_FFFF, 32'h0, 1'b1);
    add_dir(1'b0, 3'b010, 32'h20, 32'h0, 32'h8001_0000, 1'b0);
    add_dir(1'b0, 3'b010, 32'h24, 32'h0, 32'hDEAD_BEEF, 1'b0);
    add_dir(1'b0, 3'b010, 32'h10, 32'h0, 32'h0000_F000, 1'b0);
    add_dir(1'b0, 3'b010, 32'h00, 32'h0, INIT0, 1'b0);
    foreach (dirs[i]) begin
      do_req(dirs[i].we, dirs[i].f3, dirs[i].addr, dirs[i].wd, 1'b0, 1'b1,
             dirs[i].erd, dirs[i].eerr, acc);
    end
    drain();

    // Stream of 4 loads with req_valid never dropped
    resp_before = n_resp;
    prev_acc = 0;
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, 3'b010, 32'($urandom_range(0, DEPTH - 1)) << 2, 32'h0, 1'b1, 1'b0,
             32'h0, 1'b0, acc);
      if (i > 0) check("stream_spacing", acc - prev_acc, LATENCY + 2);
      prev_acc = acc;
    end
    req_valid = 1'b0;
    drain();
    repeat (LATENCY + 3) @(negedge clk);
    check("stream_pulses", n_resp - resp_before, 32'd4);

    // Randomised traffic against the model
    for (int i = 0; i < 80; i++) begin
      logic [31:0] a;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6) a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else if (r < 8) a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      else a = $urandom();
      do_req(1'($urandom()), 3'($urandom_range(0, 7)), a, $urandom(), 1'($urandom()), 1'b0,
             32'h0, 1'b0, acc);
    end
    req_valid = 1'b0;
    drain();

    // Reset in the middle of a store: nothing committed, no response
    do_req(1'b1, 3'b010, 32'h08, 32'h1234_5678, 1'b0, 1'b0, 32'h0, 1'b0, acc);
    void'(sb.pop_back());
    reset = 1'b0;
    #1;
    check_reset_outputs("midbusy");
    model_reset();
    repeat (2) @(negedge clk);
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h08;
    reset      = 1'b1;
    wait_init("reinit");
    do_req(1'b0, 3'b010, 32'h08, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, acc);
    do_req(1'b0, 3'b010, 32'h24, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0, acc);
    do_req(1'b0, 3'b010, 32'h00, 32'h0, 1'b0, 1'b1, INIT0, 1'b0, acc);
    drain();
    repeat (LATENCY + 3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
Name: data_mem_ctrl

Overview:
- Parametrised, multi-cycle data memory for the RV32 core's MEM stage; successor to the byte-only data memory.
- Supports all RV32I load/store widths (LB/LH/LW/LBU/LHU, SB/SH/SW), configurable depth and access latency, and a valid/ready request handshake with a registered response.
- Flags misaligned, out-of-range and illegal-Funct3 accesses; clears its own array after reset via a hardware sweep.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, 4..4096; IW = $clog2(DEPTH).
- LATENCY, 1, BUSY cycles per access; 1..15.
- INIT_WORD0, 32'h0A000000, value written to word 0 during the init sweep; all other words are written 0.

Ports:
- clk  in  1  Rising-edge clock.
- reset  in  1  Asynchronous, active-low reset; 0 = in reset.
- req_valid  in  1  Request present.
- req_ready  out  1  Controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I Funct3 of the load/store.
- req_addr  in  32  Byte address.
- req_wdata  in  32  Store data, right-aligned.
- resp_valid  out  1  One-cycle response pulse.
- resp_rdata  out  32  Extended load data; 0 for stores and errors.
- resp_err  out  1  Access rejected; qualified by resp_valid.
- init_done  out  1  Init sweep complete; stays 1 until the next reset.

Behaviour:
- Reset (reset=0, asynchronous):
  - Outputs go to 0 immediately: req_ready, resp_valid, resp_rdata, resp_err, init_done.
  - FSM goes to INIT with the sweep counter at 0.
  - Any in-flight request is dropped and any pending store is not committed.
  - Array contents are unspecified until the sweep finishes.
- FSM states: INIT, IDLE, BUSY, RESP.
- INIT:
  - Each cycle writes word[cnt] (INIT_WORD0 when cnt=0, else 0) and increments cnt.
  - After word DEPTH-1 is written, goes to IDLE and sets init_done=1.
  - Takes exactly DEPTH cycles from reset release. req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - On req_valid & req_ready at a clock edge, latch we, funct3, addr and wdata, load the busy counter with LATENCY-1, and go to BUSY.
  - Inputs are don't-care once latched.
- BUSY:
  - req_ready=0.
  - Decrement the counter each cycle. When it reaches 0, the edge that ends BUSY:
    - commits the store (if legal),
    - registers resp_rdata/resp_err,
    - moves to RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then go to IDLE.
- Timing:
  - resp_valid is high during the cycle after the LATENCY-th edge following the accept edge.
  - Back-to-back requests are therefore accepted every LATENCY+2 cycles.
  - resp_rdata/resp_err hold their values until the next response.
- Decode:
  - Word index = addr[IW+1:2]; byte lane = addr[1:0].
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
- Errors (resp_err=1, resp_rdata=0, no write):
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]≠0.
  - Out of range: addr[31:IW+2] ≠ 0.
  - Illegal Funct3: loads 011/110/111; stores with funct3 ≥ 011.
- Loads:
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - Byte lane n selects bits [8n+7:8n]. Halfword lane 0 selects [15:0], lane 2 selects [31:16].
- Stores:
  - Read-modify-write of the addressed word.
  - SB writes req_wdata[7:0] into lane n; SH writes wdata[15:0] into the selected half; SW writes the whole word.
  - Other bytes of the word are preserved.
  - Store responses have resp_rdata=0.
- A load issued after a store's response observes the stored data; there is no forwarding requirement within one access.

Test Plan:
- Release reset, hold req_valid=1 -> req_ready stays 0 for exactly DEPTH (64) cycles, then init_done=1. LW addr 0 -> 0x0A000000; LW addr 0xFC -> 0.
- SB wdata 0x000000F0 to addr 0x11, then LB addr 0x11 -> 0xFFFFFFF0; LBU -> 0x000000F0; LW addr 0x10 -> 0x0000F000.
- SH 0x8001 to addr 0x22, then LH addr 0x22 -> 0xFFFF8001 and LHU -> 0x00008001. SW 0xDEADBEEF to addr 0x24, then LW -> 0xDEADBEEF. With LATENCY=3, resp_valid rises 3 edges after the accept edge.
- LH addr 0x23, LW addr 0x26, SW addr 0x100 (DEPTH=64), and load Funct3 011 -> resp_err=1 and rdata 0 each time. A following LW confirms the target words are unchanged.
- Assert reset=0 mid-BUSY of SW 0x12345678 to addr 0x8 -> outputs 0 immediately and no resp_valid. After the re-sweep, LW addr 0x8 -> 0.
- req_valid held high continuously with a stream of 4 loads -> exactly 4 resp_valid pulses spaced LATENCY+2 cycles apart, and each request is accepted only while req_ready=1.
